lsu_axi_master: RTL and testbench



---
 rtl/axi_lite_if.sv | 28 ++
 rtl/lsu_axi_master.sv | 116 +++++++++++
 tb/tb_lsu_axi_master.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_if.sv
// axi_lite_if: 32-bit AXI-lite channel bundle with master and slave views
interface axi_lite_if;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/lsu_axi_master.sv
// lsu_axi_master: single-outstanding LSU to AXI-lite master bridge; define LSU_MISALIGN_CHECK_EN to reject misaligned requests
module lsu_axi_master (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  axi_lite_if.master  axi
);
  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR, WR_RESP, RESP} state_t;
  state_t      state_q;
  logic [1:0]  off_q;
  logic [1:0]  size_q;
  logic        accept;
  logic        misalign;
  logic        aw_done;
  logic        w_done;
  logic [3:0]  strb;
  logic [31:0] rmask;
  assign req_ready = ~rst & (state_q == IDLE | state_q == RESP);
  assign accept = req_valid & req_ready;
  always_comb begin
`ifdef LSU_MISALIGN_CHECK_EN
    misalign = (req_size == 2'd3) | (req_size == 2'd1 & req_addr[0]) | (req_size == 2'd2 & req_addr[1:0] != 2'd0);
`else
    misalign = 1'b0;
`endif
    strb = req_size == 2'd0 ? 4'h1 : req_size == 2'd1 ? 4'h3 : 4'hf;
    rmask = size_q == 2'd0 ? 32'h0000_00ff : size_q == 2'd1 ? 32'h0000_ffff : 32'hffff_ffff;
    aw_done = ~axi.awvalid | axi.awready;
    w_done = ~axi.wvalid | axi.wready;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q     <= IDLE;
      off_q       <= '0;
      size_q      <= '0;
      axi.araddr  <= '0;
      axi.arvalid <= 1'b0;
      axi.rready  <= 1'b0;
      axi.awaddr  <= '0;
      axi.awvalid <= 1'b0;
      axi.wdata   <= '0;
      axi.wstrb   <= '0;
      axi.wvalid  <= 1'b0;
      axi.bready  <= 1'b0;
      resp_valid  <= 1'b0;
      resp_rdata  <= '0;
      resp_err    <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state_q)
        IDLE, RESP: begin
          state_q <= IDLE;
          if (accept) begin
            off_q      <= req_addr[1:0];
            size_q     <= req_size;
            axi.araddr <= req_addr;
            axi.awaddr <= req_addr;
            axi.wdata  <= req_wdata << {req_addr[1:0], 3'b000};
            axi.wstrb  <= strb << req_addr[1:0];
            if (misalign) begin
              state_q    <= RESP;
              resp_valid <= 1'b1;
              resp_rdata <= '0;
              resp_err   <= 1'b1;
            end else if (req_wen) begin
              state_q     <= WR;
              axi.awvalid <= 1'b1;
              axi.wvalid  <= 1'b1;
            end else begin
              state_q     <= RD_ADDR;
              axi.arvalid <= 1'b1;
            end
          end
        end
        RD_ADDR:
          if (axi.arready) begin
            state_q     <= RD_DATA;
            axi.arvalid <= 1'b0;
            axi.rready  <= 1'b1;
          end
        RD_DATA:
          if (axi.rvalid) begin
            state_q    <= RESP;
            axi.rready <= 1'b0;
            resp_valid <= 1'b1;
            resp_rdata <= (axi.rdata >> {off_q, 3'b000}) & rmask;
            resp_err   <= axi.rresp != 2'b00;
          end
        WR: begin
          if (axi.awready) axi.awvalid <= 1'b0;
          if (axi.wready) axi.wvalid <= 1'b0;
          if (aw_done & w_done) begin
            state_q    <= WR_RESP;
            axi.bready <= 1'b1;
          end
        end
        WR_RESP:
          if (axi.bvalid) begin
            state_q    <= RESP;
            axi.bready <= 1'b0;
            resp_valid <= 1'b1;
            resp_rdata <= '0;
            resp_err   <= axi.bresp != 2'b00;
          end
        default: state_q <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_lsu_axi_master.sv
// tb_lsu_axi_master: table-driven, hand-written and randomized checks of lsu_axi_master against a byte-lane model
module tb_lsu_axi_master;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wen = 1'b0;
  logic [31:0] req_addr = '0;
  logic [1:0]  req_size = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  int          errors = 0;
  int          checks = 0;
  axi_lite_if ax();
  lsu_axi_master dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .axi(ax)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [1:0]  rsp;
    int          ard, awd, wdd, rdd, bd;
    logic [31:0] e_rdata;
    logic        e_err;
    logic [3:0]  e_strb;
    logic [31:0] e_wdata;
    logic        e_nobus;
  } vec_t;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask
  function automatic vec_t mk(input logic wen, input logic [31:0] addr, input logic [1:0] size,
                              input logic [31:0] wd, input logic [31:0] rd, input logic [1:0] rsp,
                              input int ard, input int awd, input int wdd, input int rdd, input int bd,
                              input logic [31:0] er, input logic ee, input logic [3:0] es,
                              input logic [31:0] ew, input logic en);
    vec_t v;
    v.wen = wen; v.addr = addr; v.size = size; v.wdata = wd; v.rdata = rd; v.rsp = rsp;
    v.ard = ard; v.awd = awd; v.wdd = wdd; v.rdd = rdd; v.bd = bd;
    v.e_rdata = er; v.e_err = ee; v.e_strb = es; v.e_wdata = ew; v.e_nobus = en;
    return v;
  endfunction
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    int n = v.size == 2'd0 ? 1 : v.size == 2'd1 ? 2 : 4;
    int off = int'(v.addr[1:0]);
`ifdef LSU_MISALIGN_CHECK_EN
    r.e_nobus = (v.size == 2'd3) || (off % n != 0);
`else
    r.e_nobus = 1'b0;
`endif
    r.e_strb = '0;
    r.e_wdata = '0;
    r.e_rdata = '0;
    for (int b = 0; b < 4; b++) begin
      if (b >= off && b < off + n) r.e_strb[b] = 1'b1;
      if (b >= off) r.e_wdata[8*b +: 8] = v.wdata[8*(b-off) +: 8];
      if (b < n && b + off < 4) r.e_rdata[8*b +: 8] = v.rdata[8*(b+off) +: 8];
    end
    if (v.wen || r.e_nobus) r.e_rdata = '0;
    r.e_err = r.e_nobus ? 1'b1 : (v.rsp != 2'b00);
    return r;
  endfunction
  task automatic run(input vec_t v, input bit chain, input vec_t nv);
    int lat, ar_c = 0, aw_c = 0, w_c = 0, r_c = 0, b_c = 0;
    bit ar_d = 0, aw_d = 0, w_d = 0, r_d = 0, b_d = 0;
    bit pav = 0, paw = 0, pw = 0, prr = 0, pbr = 0;
    bit ars = 0, aws = 0, ws = 0, bad = 0, got = 0;
    if (!req_valid) begin
      req_wen = v.wen; req_addr = v.addr; req_size = v.size; req_wdata = v.wdata; req_valid = 1'b1;
    end
    chk("req_ready", req_ready, 1);
    ax.rdata = v.rdata; ax.rresp = v.rsp; ax.bresp = v.rsp;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = v.e_nobus ? 1 : v.wen ? 3 + (v.awd > v.wdd ? v.awd : v.wdd) + v.bd : 3 + v.ard + v.rdd;
    for (int cyc = 1; cyc <= 60 && !got; cyc++) begin
      if (cyc > 1) @(negedge clk);
      ar_d |= pav & ax.arready;
      aw_d |= paw & ax.awready;
      w_d  |= pw & ax.wready;
      r_d  |= prr & ax.rvalid;
      b_d  |= pbr & ax.bvalid;
      ax.arready = 0; ax.awready = 0; ax.wready = 0; ax.rvalid = 0; ax.bvalid = 0;
      if (resp_valid) begin
        got = 1;
        chk("latency", cyc, lat);
        chk("resp_err", resp_err, v.e_err);
        chk("resp_rdata", resp_rdata, v.e_rdata);
      end else begin
        if (ax.arvalid) begin
          if (!ars) chk("araddr", ax.araddr, v.addr);
          else if (ax.araddr !== v.addr) bad = 1;
          if (ar_d) bad = 1;
          ars = 1;
        end else if (ars && !ar_d) bad = 1;
        if (ax.awvalid) begin
          if (!aws) chk("awaddr", ax.awaddr, v.addr);
          else if (ax.awaddr !== v.addr) bad = 1;
          if (aw_d) bad = 1;
          aws = 1;
        end else if (aws && !aw_d) bad = 1;
        if (ax.wvalid) begin
          if (!ws) begin
            chk("wdata", ax.wdata, v.e_wdata);
            chk("wstrb", ax.wstrb, v.e_strb);
          end else if (ax.wdata !== v.e_wdata || ax.wstrb !== v.e_strb) bad = 1;
          if (w_d) bad = 1;
          ws = 1;
        end else if (ws && !w_d) bad = 1;
        ax.arready = ax.arvalid && ar_c >= v.ard;
        if (ax.arvalid) ar_c++;
        ax.awready = ax.awvalid && aw_c >= v.awd;
        if (ax.awvalid) aw_c++;
        ax.wready = ax.wvalid && w_c >= v.wdd;
        if (ax.wvalid) w_c++;
        if (ar_d && !r_d) begin
          ax.rvalid = r_c >= v.rdd;
          r_c++;
        end
        if (aw_d && w_d && !b_d) begin
          ax.bvalid = b_c >= v.bd;
          b_c++;
        end
        pav = ax.arvalid; paw = ax.awvalid; pw = ax.wvalid; prr = ax.rready; pbr = ax.bready;
      end
    end
    chk("resp_seen", got, 1);
    chk("chan_stable", bad, 0);
    chk("bus_used", v.e_nobus ? (ars | aws | ws) : (v.wen ? (aws & ws) : ars), !v.e_nobus);
    if (chain) begin
      req_wen = nv.wen; req_addr = nv.addr; req_size = nv.size; req_wdata = nv.wdata; req_valid = 1'b1;
    end else begin
      @(negedge clk);
      chk("resp_pulse", resp_valid, 0);
    end
  endtask
  vec_t tbl[10];
  vec_t rq[40];
  initial begin
    ax.arready = 0; ax.awready = 0; ax.wready = 0; ax.rvalid = 0; ax.bvalid = 0;
    ax.rdata = '0; ax.rresp = '0; ax.bresp = '0;
    tbl[0] = mk(0, 32'ha000_0048, 2, 0, 32'h0000_1234, 0, 0, 0, 0, 0, 0, 32'h1234, 0, 0, 0, 0);
    tbl[1] = mk(1, 32'h8000_0003, 0, 32'h1234_56ab, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h8, 32'hab00_0000, 0);
    tbl[2] = mk(0, 32'h8000_0002, 1, 0, 32'hbeef_0000, 0, 3, 0, 0, 2, 0, 32'h0000_beef, 0, 0, 0, 0);
    tbl[3] = mk(1, 32'h8000_0010, 2, 32'hdead_beef, 0, 2'b10, 0, 0, 2, 0, 1, 0, 1, 4'hf, 32'hdead_beef, 0);
    tbl[5] = mk(0, 32'h1000_0002, 0, 0, 32'h1122_3344, 2'b11, 1, 0, 0, 0, 0, 32'h22, 1, 0, 0, 0);
    tbl[6] = mk(1, 32'h0000_0002, 1, 32'hffff_5678, 0, 0, 0, 2, 0, 0, 1, 0, 0, 4'hc, 32'h5678_0000, 0);
    tbl[8] = mk(1, 32'h0000_0001, 0, 32'h0000_005a, 0, 0, 0, 1, 1, 0, 0, 0, 0, 4'h2, 32'h0000_5a00, 0);
`ifdef LSU_MISALIGN_CHECK_EN
    tbl[4] = mk(0, 32'h8000_0001, 1, 0, 32'h00ab_cd00, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    tbl[7] = mk(0, 32'h0000_0004, 3, 0, 32'hcafe_f00d, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    tbl[9] = mk(1, 32'h2000_0006, 2, 32'h1122_3344, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
`else
    tbl[4] = mk(0, 32'h8000_0001, 1, 0, 32'h00ab_cd00, 0, 0, 0, 0, 0, 0, 32'h0000_abcd, 0, 0, 0, 0);
    tbl[7] = mk(0, 32'h0000_0004, 3, 0, 32'hcafe_f00d, 0, 0, 0, 0, 0, 0, 32'hcafe_f00d, 0, 0, 0, 0);
    tbl[9] = mk(1, 32'h2000_0006, 2, 32'h1122_3344, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'hc, 32'h3344_0000, 0);
`endif
    repeat (2) @(negedge clk);
    chk("rst_ready", req_ready, 0);
    chk("rst_valids", {ax.arvalid, ax.awvalid, ax.wvalid, ax.rready, ax.bready, resp_valid, resp_err}, 0);
    chk("rst_data", ax.araddr | ax.awaddr | ax.wdata | resp_rdata, 0);
    chk("rst_wstrb", ax.wstrb, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", req_ready, 1);
    for (int i = 0; i < 10; i++) run(tbl[i], 0, tbl[i]);
    run(tbl[0], 1, tbl[1]);
    run(tbl[1], 1, tbl[2]);
    run(tbl[2], 0, tbl[2]);
    req_wen = 0; req_addr = 32'h0000_0040; req_size = 2; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("mr_arvalid", ax.arvalid, 1);
    ax.arready = 1;
    @(negedge clk);
    ax.arready = 0;
    chk("mr_rready", ax.rready, 1);
    rst = 1'b1;
    ax.rvalid = 1;
    ax.rdata = 32'h5555_aaaa;
    @(negedge clk);
    chk("mr_valids", {ax.arvalid, ax.awvalid, ax.wvalid, ax.rready, ax.bready, resp_valid}, 0);
    chk("mr_ready_in_rst", req_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("mr_ready", req_ready, 1);
    chk("mr_no_consume", {ax.rready, resp_valid}, 0);
    ax.rvalid = 0;
    run(tbl[0], 0, tbl[0]);
    for (int i = 0; i < 40; i++) begin
      vec_t v;
      v = mk($urandom_range(0, 1), $urandom, 2'($urandom_range(0, 3)), $urandom, $urandom,
             2'($urandom_range(0, 3)), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom_range(0, 3), 0, 0, 0, 0, 0);
      rq[i] = model(v);
    end
    for (int i = 0; i < 40; i++) run(rq[i], i < 39 && i % 4 == 1, rq[i < 39 ? i + 1 : i]);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
